// File: rtl/param_word_ram_pkg.sv
// Shared types and constants for the byte-stream-loaded word RAM.
package param_word_ram_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // Address/counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/param_word_ram_if.sv
// Load stream, read port and status bundle for param_word_ram.
interface param_word_ram_if
  import param_word_ram_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 10
);
  localparam int unsigned ADDR_W = clog2_min1(DEPTH);

  logic                load_start;
  logic                in_valid;
  logic [BYTE_W-1:0]   in_byte;
  logic                in_ready;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_data;
  logic                load_done;
  logic                load_error;
  logic [ADDR_W:0]     words_loaded;

  modport master (
    output load_start, in_valid, in_byte, rd_addr,
    input  in_ready, rd_data, load_done, load_error, words_loaded
  );

  modport slave (
    input  load_start, in_valid, in_byte, rd_addr,
    output in_ready, rd_data, load_done, load_error, words_loaded
  );
endinterface

// File: rtl/param_word_store.sv
// DEPTH x DATA_W distributed RAM: synchronous write, asynchronous read, zero beyond DEPTH.
module param_word_store #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 10,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata = '0;
    if (32'(raddr) < DEPTH) rdata = mem[raddr];
  end

endmodule

// File: rtl/param_word_ram.sv
// Assembles a little-endian byte stream into words and loads them into a word RAM.
module param_word_ram
  import param_word_ram_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  param_word_ram_if.slave bus
);

  localparam int unsigned ADDR_W = clog2_min1(DEPTH);
  localparam int unsigned BYTES  = DATA_W / BYTE_W;
  localparam int unsigned CNT_W  = clog2_min1(BYTES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic              in_ready_q, in_ready_d;
  logic              load_done_q, load_done_d;
  logic              load_error_q, load_error_d;

  logic              accept_c;
  logic              last_byte_c;
  logic              we_c;
  logic [DATA_W-1:0] wdata_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= '0;
      addr_q       <= '0;
      words_q      <= '0;
      asm_q        <= '0;
      in_ready_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      addr_q       <= addr_d;
      words_q      <= words_d;
      asm_q        <= asm_d;
      in_ready_q   <= in_ready_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    addr_d       = addr_q;
    words_d      = words_q;
    asm_d        = asm_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
    we_c         = 1'b0;

    accept_c    = bus.in_valid && in_ready_q;
    last_byte_c = (byte_cnt_q == CNT_W'(BYTES - 1));

    // The closing byte goes straight into the top lane of the written word.
    wdata_c = asm_q;
    wdata_c[(BYTES-1)*BYTE_W +: BYTE_W] = bus.in_byte;

    if (bus.load_start) begin
      state_d      = ST_LOAD;
      byte_cnt_d   = '0;
      addr_d       = '0;
      words_d      = '0;
      asm_d        = '0;
      load_done_d  = 1'b0;
      load_error_d = 1'b0;
    end else if (accept_c) begin
      unique case (state_q)
        ST_LOAD: begin
          for (int unsigned i = 0; i < BYTES; i++) begin
            if (byte_cnt_q == CNT_W'(i)) asm_d[i*BYTE_W +: BYTE_W] = bus.in_byte;
          end
          if (last_byte_c) begin
            we_c       = 1'b1;
            byte_cnt_d = '0;
            words_d    = words_q + (ADDR_W+1)'(1);
            if (addr_q == ADDR_W'(DEPTH - 1)) begin
              state_d     = ST_DONE;
              load_done_d = 1'b1;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_d      = ST_ERR;
          load_error_d = 1'b1;
        end
        default: ;
      endcase
    end

    in_ready_d = (state_d != ST_IDLE);
  end

  // Write is suppressed in a reset cycle so an abandoned load leaves no trace.
  param_word_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk   (clk),
    .we    (we_c && rst_n),
    .waddr (addr_q),
    .wdata (wdata_c),
    .raddr (bus.rd_addr),
    .rdata (bus.rd_data)
  );

  assign bus.in_ready     = in_ready_q;
  assign bus.load_done    = load_done_q;
  assign bus.load_error   = load_error_q;
  assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_param_word_ram.sv
// Directed and randomized bench for param_word_ram against a byte-count reference model.
module tb_param_word_ram;
  import param_word_ram_pkg::*;

  localparam int unsigned DW   = 32;
  localparam int unsigned DP   = 10;
  localparam int unsigned BY   = 4;
  localparam int unsigned AW   = 4;
  localparam int unsigned DW_B = 16;
  localparam int unsigned DP_B = 4;
  localparam int unsigned AW_B = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_word_ram_if #(.DATA_W(DW),   .DEPTH(DP))   a_if ();
  param_word_ram_if #(.DATA_W(DW_B), .DEPTH(DP_B)) b_if ();

  param_word_ram #(.DATA_W(DW), .DEPTH(DP)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  param_word_ram #(.DATA_W(DW_B), .DEPTH(DP_B)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a load is just a running count of accepted bytes.
  logic [DW-1:0] m_mem [DP];
  bit            m_known [DP];
  bit            m_active = 1'b0;
  bit            m_done   = 1'b0;
  bit            m_err    = 1'b0;
  int            m_nbytes = 0;
  logic [DW-1:0] m_acc    = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit ls, input bit v, input logic [7:0] b);
    if (!r) begin
      m_active = 1'b0; m_nbytes = 0; m_done = 1'b0; m_err = 1'b0;
    end else if (ls) begin
      m_active = 1'b1; m_nbytes = 0; m_done = 1'b0; m_err = 1'b0;
    end else if (m_active && v) begin
      if (m_nbytes == int'(DP * BY)) begin
        m_err = 1'b1;
      end else begin
        if (m_nbytes % BY == 0) m_acc = '0;
        m_acc = m_acc | (DW'(b) << (8 * (m_nbytes % BY)));
        m_nbytes++;
        if (m_nbytes % BY == 0) begin
          m_mem[m_nbytes / BY - 1]   = m_acc;
          m_known[m_nbytes / BY - 1] = 1'b1;
        end
        if (m_nbytes == int'(DP * BY)) m_done = 1'b1;
      end
    end
  endtask

  task automatic rd_a(input int addr, output logic [DW-1:0] d);
    a_if.rd_addr = AW'(addr);
    #1;
    d = a_if.rd_data;
  endtask

  task automatic check_outputs(input string tag);
    int unsigned   ra;
    logic [DW-1:0] d;
    chk({tag, ".in_ready"},   64'(a_if.in_ready),     64'(m_active));
    chk({tag, ".words"},      64'(a_if.words_loaded), 64'(m_nbytes / BY));
    chk({tag, ".load_done"},  64'(a_if.load_done),    64'(m_done));
    chk({tag, ".load_error"}, 64'(a_if.load_error),   64'(m_err));
    ra = $urandom_range(0, 15);
    rd_a(int'(ra), d);
    if (ra >= DP) chk({tag, ".rd_oor"}, 64'(d), 64'(0));
    else if (m_known[ra]) chk({tag, ".rd"}, 64'(d), 64'(m_mem[ra]));
  endtask

  task automatic step(input bit r, input bit ls, input bit v, input logic [7:0] b, input string tag);
    rst_n           = r;
    a_if.load_start = ls;
    a_if.in_valid   = v;
    a_if.in_byte    = b;
    @(posedge clk);
    model(r, ls, v, b);
    #1;
    rst_n           = 1'b1;
    a_if.load_start = 1'b0;
    a_if.in_valid   = 1'b0;
    a_if.in_byte    = '0;
    check_outputs(tag);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    int            k;
    a_if.load_start = 1'b0; a_if.in_valid = 1'b0; a_if.in_byte = '0; a_if.rd_addr = '0;
    b_if.load_start = 1'b0; b_if.in_valid = 1'b0; b_if.in_byte = '0; b_if.rd_addr = '0;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 8'h00, "reset0");
    step(1'b0, 1'b0, 1'b1, 8'h00, "reset1");
    chk("reset.in_ready", 64'(a_if.in_ready), 64'(0));

    // Full load of 0x00..0x27
    step(1'b1, 1'b1, 1'b0, 8'h00, "start");
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'(i), "load0");
      if (i == 38) chk("done_early", 64'(a_if.load_done), 64'(0));
    end
    rd_a(0, d); chk("full.w0", 64'(d), 64'(32'h03020100));
    rd_a(9, d); chk("full.w9", 64'(d), 64'(32'h27262524));
    chk("full.words", 64'(a_if.words_loaded), 64'(10));
    chk("full.done",  64'(a_if.load_done),    64'(1));
    chk("full.err",   64'(a_if.load_error),   64'(0));

    // Byte after completion
    step(1'b1, 1'b0, 1'b1, 8'hFF, "extra");
    chk("extra.err",  64'(a_if.load_error), 64'(1));
    chk("extra.done", 64'(a_if.load_done),  64'(1));
    rd_a(9, d); chk("extra.w9", 64'(d), 64'(32'h27262524));
    step(1'b1, 1'b0, 1'b1, 8'hFE, "extra2");
    chk("extra2.err", 64'(a_if.load_error), 64'(1));
    step(1'b1, 1'b1, 1'b0, 8'h00, "restart");
    chk("restart.err",  64'(a_if.load_error), 64'(0));
    chk("restart.done", 64'(a_if.load_done),  64'(0));

    // Abort mid-word, then reload from 0x80
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 8'(8'hA0 + i), "partial");
    step(1'b1, 1'b1, 1'b0, 8'h00, "abort");
    chk("abort.words", 64'(a_if.words_loaded), 64'(0));
    rd_a(1, d); chk("abort.w1_kept", 64'(d), 64'(32'h07060504));
    rd_a(0, d); chk("abort.w0_full", 64'(d), 64'(32'hA3A2A1A0));
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h80 + i), "load80");
    rd_a(0, d); chk("load80.w0", 64'(d), 64'(32'h83828180));

    // load_start coincident with an accepted byte in DONE
    step(1'b1, 1'b1, 1'b1, 8'h55, "ls_byte");
    chk("ls_byte.err",   64'(a_if.load_error),   64'(0));
    chk("ls_byte.done",  64'(a_if.load_done),    64'(0));
    chk("ls_byte.ready", 64'(a_if.in_ready),     64'(1));
    chk("ls_byte.words", 64'(a_if.words_loaded), 64'(0));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h10 + i), "after_ls");
    rd_a(0, d); chk("after_ls.w0", 64'(d), 64'(32'h13121110));

    // Reset during the third word, including a would-be word-closing byte
    step(1'b1, 1'b1, 1'b0, 8'h00, "start36");
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h60 + i), "pre_rst");
    step(1'b0, 1'b0, 1'b1, 8'hEE, "rst_mid");
    chk("rst_mid.ready", 64'(a_if.in_ready),     64'(0));
    chk("rst_mid.words", 64'(a_if.words_loaded), 64'(0));
    chk("rst_mid.done",  64'(a_if.load_done),    64'(0));
    chk("rst_mid.err",   64'(a_if.load_error),   64'(0));
    rd_a(0, d);  chk("rst_mid.w0",  64'(d), 64'(32'h63626160));
    rd_a(2, d);  chk("rst_mid.w2",  64'(d), 64'(32'h8B8A8988));
    rd_a(12, d); chk("rst_mid.a12", 64'(d), 64'(0));
    step(1'b1, 1'b0, 1'b1, 8'h77, "idle_byte");
    chk("idle_byte.err",   64'(a_if.load_error),   64'(0));
    chk("idle_byte.words", 64'(a_if.words_loaded), 64'(0));

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 199) != 0, $urandom_range(0, 79) == 0,
           $urandom_range(0, 3) != 0, 8'($urandom), "rand");
    end

    // 16-bit, depth-4 instance with in_valid on every other cycle
    b_if.load_start = 1'b1;
    @(posedge clk); #1;
    b_if.load_start = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      b_if.in_valid = (cyc % 2 == 0);
      b_if.in_byte  = 8'(8'h50 + k);
      @(posedge clk); #1;
      if (b_if.in_valid) k++;
      b_if.in_valid = 1'b0;
      chk("b.done",  64'(b_if.load_done),    64'(k == 8));
      chk("b.words", 64'(b_if.words_loaded), 64'(k / 2));
    end
    chk("b.err", 64'(b_if.load_error), 64'(0));
    for (int w = 0; w < int'(DP_B); w++) begin
      b_if.rd_addr = AW_B'(w);
      #1;
      chk("b.word", 64'(b_if.rd_data), 64'(((8'h51 + 2 * w) << 8) | (8'h50 + 2 * w)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_word_ram.md
PARAM_WORD_RAM -- requirements
Module: param_word_ram

Interface
REQ-001 The block SHALL be parametrised by DATA_W, default 32, the word width in bits; it is a multiple of 8 and at least 8.
REQ-002 The block SHALL be parametrised by DEPTH, default 10, the number of words stored.
REQ-003 The block SHALL derive ADDR_W = max(1, clog2(DEPTH)) and BYTES = DATA_W/8 as local constants.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 load_start  input  1  one-cycle pulse; aborts any load in progress and begins a new load at word 0.
REQ-007 in_valid  input  1  byte stream valid.
REQ-008 in_byte  input  8  byte stream data, little-endian within each word.
REQ-009 in_ready  output  1  the block accepts in_byte when in_valid and in_ready are both high.
REQ-010 rd_addr  input  ADDR_W  read address.
REQ-011 rd_data  output  DATA_W  asynchronous read of the word at rd_addr.
REQ-012 load_done  output  1  high when all DEPTH words have been written.
REQ-013 load_error  output  1  sticky; high when a byte arrived after the load was complete.
REQ-014 words_loaded  output  ADDR_W+1  count of complete words written in the current load.

Function
REQ-015 The block SHALL implement a state machine with states IDLE, LOAD, DONE and ERR.
REQ-016 Reset and the FSM SHALL behave as follows:
- Reset enters IDLE.
- load_start from any state enters LOAD and clears the byte counter, word address, words_loaded, load_done and load_error.
REQ-017 in_ready SHALL be high in LOAD, DONE and ERR, and low in IDLE; in IDLE, bytes are not accepted and are not flagged.
REQ-018 In LOAD, each accepted byte SHALL be placed into lane byte_cnt of a DATA_W shift/assembly register; byte_cnt increments and wraps at BYTES-1.
REQ-019 On acceptance of the last byte of a word (byte_cnt = BYTES-1), the block SHALL write the assembled word to the current word address in that same cycle, using that byte as the top lane, and then increment the address and words_loaded.
REQ-020 Write-to-read latency SHALL be one cycle: rd_data reflects the new word from the cycle after the write edge.
REQ-021 When the word written is at address DEPTH-1, the FSM SHALL enter DONE and load_done SHALL assert in the next cycle; the address SHALL NOT wrap.
REQ-022 In DONE, an accepted byte SHALL move the FSM to ERR, assert load_error, and leave RAM contents unchanged.
REQ-023 ERR SHALL keep load_done high, keep load_error high, and discard further bytes until load_start or reset.
REQ-024 If load_start and an accepted byte occur in the same cycle, load_start SHALL win and the byte SHALL be discarded.
REQ-025 A load_start mid-word SHALL discard the partial word; previously written RAM words SHALL persist until overwritten.
REQ-026 Reading a rd_addr >= DEPTH SHALL return zero.
REQ-027 RAM contents SHALL NOT be cleared by reset; only the control state is reset.

Reset
REQ-028 While rst_n is low at a clock edge, the block SHALL set: FSM = IDLE, byte_cnt = 0, address = 0, words_loaded = 0, load_done = 0, load_error = 0, in_ready = 0.
REQ-029 Reset asserted mid-load SHALL abandon the load, with no write in the reset cycle.

Structure
REQ-030 The FSM state encoding SHALL live in the shared project package; the byte-width constant 8 is defined there too.
REQ-031 Storage SHALL be one sub-module, param_word_store, a DEPTH x DATA_W distributed RAM with synchronous write and asynchronous read; the control logic sits in param_word_ram.

Verification
REQ-032 Defaults; load_start, then 40 bytes 0x00..0x27 back-to-back -> word 0 = 0x03020100, word 9 = 0x27262524, load_done high the cycle after byte 40, words_loaded = 10, load_error = 0.
REQ-033 Full load, then one extra byte 0xFF -> load_error = 1, FSM in ERR, word 9 unchanged; a subsequent load_start clears both flags.
REQ-034 6 bytes, then load_start, then 40 bytes 0x80.. -> word 0 = 0x83828180, words_loaded counts from 0, and no write from the aborted partial word.
REQ-035 in_valid toggled every other cycle with DATA_W=16, DEPTH=4: 8 bytes -> 4 correct words, and load_done asserts only after the 8th accepted byte.
REQ-036 rst_n low during the 3rd word -> outputs take reset values; rd_addr=0 still returns the pre-reset word 0; rd_addr=12 returns 0.
REQ-037 load_start coincident with a valid byte in DONE -> byte discarded, FSM in LOAD, load_error = 0.
